// File: rtl/uart_tx_param.sv
// UART transmitter with a parameterised transmit FIFO.
// Frame: start bit, DATA_BITS data bits LSB-first, optional parity bit, STOP_BITS stop bits.
module uart_tx_param #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DIV_W-1:0]            baud_div,
    input  logic [DATA_BITS-1:0]        s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    input  logic                        clr_err
);

    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = AddrW + 1;
    localparam int unsigned BitW  = 4;
    localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AddrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q;
    logic                 overflow_q;
    logic                 push, pop, load;
    logic [DATA_BITS-1:0] head;

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic [BitW-1:0]      bit_idx_q, bit_idx_d;
    logic                 tx_q, tx_d;
    logic [DIV_W-1:0]     div_eff;
    logic                 bit_end;

    assign s_ready    = (count_q != FullCnt);
    assign push       = s_valid & s_ready;
    assign head       = mem_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign tx         = tx_q;
    assign busy       = (state_q != StIdle) || (count_q != '0);

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
            count_q <= count_q + CntW'(push) - CntW'(pop);
            // A rejected write on the same edge as clr_err keeps the flag set.
            if (s_valid && !s_ready) overflow_q <= 1'b1;
            else if (clr_err)        overflow_q <= 1'b0;
        end
    end

    // A divisor of zero behaves as one clock per bit.
    assign div_eff = (div_q == '0) ? DIV_W'(1) : div_q;
    assign bit_end = (cnt_q == div_eff);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        par_d     = par_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        load      = 1'b0;
        pop       = 1'b0;
        if (state_q != StIdle) cnt_d = bit_end ? DIV_W'(1) : cnt_q + DIV_W'(1);
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                load = (count_q != '0);
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_idx_q == BitW'(DATA_BITS - 1)) begin
                        bit_idx_d = '0;
                        if (PARITY != 0) begin
                            state_d = StPar;
                            tx_d    = par_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + BitW'(1);
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            StPar: begin
                if (bit_end) begin
                    state_d   = StStop;
                    tx_d      = 1'b1;
                    bit_idx_d = '0;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (bit_idx_q == BitW'(STOP_BITS - 1)) begin
                        if (count_q != '0) begin
                            load = 1'b1;
                        end else begin
                            state_d = StIdle;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + BitW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Starting a frame: pop the head and freeze word, parity and divisor for its duration.
        if (load) begin
            pop     = 1'b1;
            state_d = StStart;
            shift_d = head;
            par_d   = (^head) ^ (PARITY == 1);
            div_d   = baud_div;
            cnt_d   = DIV_W'(1);
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            par_q     <= 1'b0;
            div_q     <= '0;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: three parameter sets share one stimulus stream and
// are compared every cycle against a frame-level queue model, plus directed frame vectors.
module tb_uart_tx_param;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [15:0] baud_div = 16'd4;
    logic [8:0]  s_data   = '0;
    logic        s_valid  = 1'b0;
    logic        clr_err  = 1'b0;

    logic       tx_w   [3];
    logic       busy_w [3];
    logic       rdy_w  [3];
    logic       ovf_w  [3];
    logic [3:0] cnt0;
    logic [2:0] cnt1;
    logic [1:0] cnt2;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    uart_tx_param u0 (
        .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .s_data(s_data[7:0]),
        .s_valid(s_valid), .s_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]),
        .fifo_count(cnt0), .overflow(ovf_w[0]), .clr_err(clr_err)
    );

    uart_tx_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .s_data(s_data[6:0]),
        .s_valid(s_valid), .s_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]),
        .fifo_count(cnt1), .overflow(ovf_w[1]), .clr_err(clr_err)
    );

    uart_tx_param #(.DATA_BITS(9), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(2)) u2 (
        .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .s_data(s_data),
        .s_valid(s_valid), .s_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]),
        .fifo_count(cnt2), .overflow(ovf_w[2]), .clr_err(clr_err)
    );

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endfunction

    function automatic int cnt_of(input int u);
        case (u)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    // Reference model: queued words, and the line levels of the frame in flight (one per clock).
    int m_db    [3] = '{8, 7, 9};
    int m_par   [3] = '{0, 2, 1};
    int m_sb    [3] = '{1, 2, 1};
    int m_depth [3] = '{8, 4, 2};
    int fq  [3][$];
    bit lq  [3][$];
    bit m_ovf [3];

    function automatic void build(input int u, input int w, input int d);
        int nb;
        int ones;
        nb   = 1 + m_db[u] + ((m_par[u] != 0) ? 1 : 0) + m_sb[u];
        ones = 0;
        for (int b = 0; b < m_db[u]; b++) ones += (w >> b) & 1;
        for (int k = 0; k < nb; k++) begin
            bit lvl;
            if (k == 0)                                   lvl = 1'b0;
            else if (k <= m_db[u])                        lvl = bit'((w >> (k - 1)) & 1);
            else if (m_par[u] != 0 && k == m_db[u] + 1)   lvl = (m_par[u] == 2) ? bit'(ones % 2)
                                                                               : bit'(1 - ones % 2);
            else                                          lvl = 1'b1;
            for (int r = 0; r < d; r++) lq[u].push_back(lvl);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int u = 0; u < 3; u++) begin
                fq[u].delete();
                lq[u].delete();
                m_ovf[u] = 1'b0;
            end
        end else begin
            for (int u = 0; u < 3; u++) begin
                bit full;
                full = (fq[u].size() >= m_depth[u]);
                if (lq[u].size() > 0) void'(lq[u].pop_front());
                if (lq[u].size() == 0 && fq[u].size() > 0)
                    build(u, fq[u].pop_front(), (baud_div == 0) ? 1 : int'(baud_div));
                if (s_valid && !full) fq[u].push_back(int'(s_data) & ((1 << m_db[u]) - 1));
                if (s_valid && full) m_ovf[u] = 1'b1;
                else if (clr_err)    m_ovf[u] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int u = 0; u < 3; u++) begin
                check($sformatf("u%0d.tx", u), tx_w[u], (lq[u].size() > 0) ? lq[u][0] : 1'b1);
                check($sformatf("u%0d.busy", u), busy_w[u], lq[u].size() > 0 || fq[u].size() > 0);
                check($sformatf("u%0d.s_ready", u), rdy_w[u], fq[u].size() < m_depth[u]);
                check($sformatf("u%0d.fifo_count", u), cnt_of(u), fq[u].size());
                check($sformatf("u%0d.overflow", u), ovf_w[u], m_ovf[u]);
            end
        end
    end

    typedef struct {
        int unit;
        int word;
        int div;
        int nbits;
        int frame;   // bit k = line level of the k-th bit period
    } vec_t;

    vec_t vecs [5];

    task automatic do_reset();
        @(posedge clk); #2; rst_n = 1'b0;
        @(posedge clk); #2; rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input bit rst_first);
        int d;
        int n;
        logic [63:0] got;
        logic [63:0] want;
        d    = (v.div == 0) ? 1 : v.div;
        n    = v.nbits * d;
        got  = '0;
        want = '0;
        baud_div = 16'(v.div);
        if (rst_first) do_reset();
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 9'(v.word);
        @(negedge clk);
        s_valid = 1'b0;
        check($sformatf("vec u%0d first write count", v.unit), cnt_of(v.unit), 1);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            got[k]  = tx_w[v.unit];
            want[k] = 1'((v.frame >> (k / d)) & 1);
        end
        check($sformatf("vec u%0d word 0x%0h frame", v.unit, v.word), got, want);
        @(negedge clk);
        check($sformatf("vec u%0d busy after stop", v.unit), busy_w[v.unit], 1'b0);
        check($sformatf("vec u%0d idle tx", v.unit), tx_w[v.unit], 1'b1);
    endtask

    initial begin
        int bc;
        vecs[0] = '{0, 'h0A5, 4, 10, 'h34A};
        vecs[1] = '{1, 'h041, 3, 11, 'h682};
        vecs[2] = '{2, 'h1A5, 2, 12, 'hB4A};
        vecs[3] = '{0, 'h03C, 0, 10, 'h278};
        vecs[4] = '{1, 'h07F, 1, 11, 'h7FE};

        repeat (2) @(posedge clk);
        #1;
        check("reset tx", tx_w[0], 1'b1);
        check("reset busy", busy_w[0], 1'b0);
        check("reset s_ready", rdy_w[0], 1'b1);
        check("reset fifo_count", cnt0, 0);
        check("reset overflow", ovf_w[0], 1'b0);
        chk_on = 1'b1;
        #2 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b1);

        // Fill past capacity while the first frame is already running.
        do_reset();
        baud_div = 16'd2;
        bc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0 && busy_w[0]) bc++;
            if (i == 9) begin
                check("full fifo_count", cnt0, 8);
                check("full s_ready", rdy_w[0], 1'b0);
            end
            s_valid = 1'b1;
            s_data  = 9'(8'h10 + i);
        end
        @(negedge clk);
        if (busy_w[0]) bc++;
        check("overflow set", ovf_w[0], 1'b1);
        check("overflow count held", cnt0, 8);
        s_valid = 1'b0;
        clr_err = 1'b1;
        @(negedge clk);
        if (busy_w[0]) bc++;
        check("overflow cleared", ovf_w[0], 1'b0);
        clr_err = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (busy_w[0]) bc++;
            else break;
        end
        check("nine contiguous frames busy cycles", bc, 181);

        // Divisor change mid-frame applies only from the next frame.
        do_reset();
        baud_div = 16'd4;
        bc = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 9'h00F;
        @(negedge clk);
        if (busy_w[0]) bc++;
        s_data = 9'h0F0;
        @(negedge clk);
        if (busy_w[0]) bc++;
        s_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (busy_w[0]) bc++;
        end
        baud_div = 16'd8;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (busy_w[0]) bc++;
            else break;
        end
        check("baud change busy cycles", bc, 121);

        // Reset in the middle of data bit 3.
        do_reset();
        baud_div = 16'd4;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 9'h0A5;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (18) @(negedge clk);
        check("data bit 3 level", tx_w[0], 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset tx", tx_w[0], 1'b1);
        check("async reset busy", busy_w[0], 1'b0);
        check("async reset fifo_count", cnt0, 0);
        check("async reset s_ready", rdy_w[0], 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        run_vec(vecs[0], 1'b0);

        // Randomised traffic: heavy then sparse writes, occasional divisor changes and resets.
        do_reset();
        baud_div = 16'd1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            s_valid = ($urandom_range(0, (c < 1500) ? 2 : 30) == 0);
            s_data  = 9'($urandom);
            clr_err = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) baud_div = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 999) == 0) do_reset();
        end
        @(negedge clk);
        s_valid = 1'b0;
        clr_err = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
